// File: rtl/bru_pkg.sv
// Shared definitions for the branch unit with history table: brOp encodings,
// clear-engine state type and the counter reset-value helper.
package bru_pkg;

  localparam logic [4:0] BR_NONE = 5'b00000;
  localparam logic [4:0] BR_EQ   = 5'b01000;
  localparam logic [4:0] BR_NE   = 5'b01001;
  localparam logic [4:0] BR_LT   = 5'b01100;
  localparam logic [4:0] BR_GE   = 5'b01101;
  localparam logic [4:0] BR_LTU  = 5'b01110;
  localparam logic [4:0] BR_GEU  = 5'b01111;
  localparam logic [4:0] BR_JUMP = 5'b10000;

  typedef enum logic {
    IDLE,
    CLEAR
  } bht_state_t;

  // Weakly not-taken: 2^(ctr_bits-1)-1, which is 0 for single-bit counters.
  function automatic int unsigned ctr_reset_val(input int unsigned ctr_bits);
    return (32'd1 << (ctr_bits - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up/down counter step: returns cur+1 on inc, cur-1 on dec,
// clamped to [0, 2^CTR_BITS-1]. Purely combinational.
module sat_counter #(
  parameter int unsigned CTR_BITS = 2
) (
  input  logic [CTR_BITS-1:0] cur,
  input  logic                inc,
  input  logic                dec,
  output logic [CTR_BITS-1:0] nxt
);

  always_comb begin
    nxt = cur;
    if (inc && (cur != '1)) begin
      nxt = cur + 1'b1;
    end else if (dec && (cur != '0)) begin
      nxt = cur - 1'b1;
    end
  end

endmodule

// File: rtl/bru_bht.sv
// Branch resolve unit plus direct-mapped table of saturating counters with a
// sequenced clear engine. Optional counters enabled by BRU_BHT_STATS_EN.
module bru_bht
  import bru_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned BHT_DEPTH = 64,
  parameter int unsigned CTR_BITS  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] fetch_pc,
  output logic            pred_taken,
  input  logic            resolve_valid,
  input  logic [XLEN-1:0] resolve_pc,
  input  logic [XLEN-1:0] ru_rs1,
  input  logic [XLEN-1:0] ru_rs2,
  input  logic [4:0]      brOp,
  input  logic            pred_in,
  output logic            NextPCSrc,
  output logic            mispredict,
  input  logic            bht_clear,
  output logic            bht_busy
`ifdef BRU_BHT_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
`endif
);

  localparam int unsigned IDX_W = $clog2(BHT_DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BHT_DEPTH - 1);
  localparam logic [CTR_BITS-1:0] RST_VAL = CTR_BITS'(ctr_reset_val(CTR_BITS));

  logic [IDX_W-1:0]    fetch_idx;
  logic [IDX_W-1:0]    res_idx;
  logic                taken;
  logic                is_cond;
  logic                busy;
  logic                train_en;
  logic [CTR_BITS-1:0] sat_nxt;

  bht_state_t          state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [CTR_BITS-1:0] bht_q [BHT_DEPTH];
  logic [CTR_BITS-1:0] bht_d [BHT_DEPTH];

  assign fetch_idx = fetch_pc[IDX_W+1:2];
  assign res_idx   = resolve_pc[IDX_W+1:2];

  logic unused_pc_bits;
  assign unused_pc_bits = ^{fetch_pc[XLEN-1:IDX_W+2], fetch_pc[1:0],
                            resolve_pc[XLEN-1:IDX_W+2], resolve_pc[1:0]};

  always_comb begin
    taken   = 1'b0;
    is_cond = 1'b1;
    case (brOp)
      BR_EQ:   taken = (ru_rs1 == ru_rs2);
      BR_NE:   taken = (ru_rs1 != ru_rs2);
      BR_LT:   taken = ($signed(ru_rs1) <  $signed(ru_rs2));
      BR_GE:   taken = ($signed(ru_rs1) >= $signed(ru_rs2));
      BR_LTU:  taken = (ru_rs1 <  ru_rs2);
      BR_GEU:  taken = (ru_rs1 >= ru_rs2);
      default: begin
        is_cond = 1'b0;
        taken   = ((brOp & BR_JUMP) != '0);
      end
    endcase
  end

  assign NextPCSrc  = taken;
  assign mispredict = resolve_valid & is_cond & (taken != pred_in);

  assign busy       = (state_q == CLEAR);
  assign bht_busy   = busy;
  assign pred_taken = ~busy & bht_q[fetch_idx][CTR_BITS-1];
  assign train_en   = resolve_valid & is_cond & ~busy;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (bht_clear) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == LAST_IDX) begin
          state_d = IDLE;
          ptr_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  sat_counter #(.CTR_BITS(CTR_BITS)) u_sat (
    .cur (bht_q[res_idx]),
    .inc (train_en & taken),
    .dec (train_en & ~taken),
    .nxt (sat_nxt)
  );

  // Single write port: the clear engine owns it while busy, training otherwise.
  always_comb begin
    bht_d = bht_q;
    if (busy) begin
      bht_d[ptr_q] = RST_VAL;
    end else if (train_en) begin
      bht_d[res_idx] = sat_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      for (int unsigned i = 0; i < BHT_DEPTH; i++) begin
        bht_q[i] <= RST_VAL;
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      bht_q   <= bht_d;
    end
  end

`ifdef BRU_BHT_STATS_EN
  logic [31:0] stat_br_q, stat_br_d;
  logic [31:0] stat_mp_q, stat_mp_d;

  always_comb begin
    stat_br_d = stat_br_q;
    stat_mp_d = stat_mp_q;
    if (train_en && (stat_br_q != '1)) begin
      stat_br_d = stat_br_q + 32'd1;
    end
    if (mispredict && (stat_mp_q != '1)) begin
      stat_mp_d = stat_mp_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;
`endif

endmodule

// File: tb/tb_bru_bht.sv
// Scoreboard bench for bru_bht: driver pushes reference-model expectations,
// a negedge monitor pops and compares against the combinational outputs.
`timescale 1ns/1ps
module tb_bru_bht;

  localparam int DEPTH   = 64;
  localparam int CTR_MAX = 3;
  localparam int CTR_RST = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] fetch_pc;
  logic        pred_taken;
  logic        resolve_valid;
  logic [31:0] resolve_pc;
  logic [31:0] ru_rs1;
  logic [31:0] ru_rs2;
  logic [4:0]  brOp;
  logic        pred_in;
  logic        NextPCSrc;
  logic        mispredict;
  logic        bht_clear;
  logic        bht_busy;
`ifdef BRU_BHT_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  bru_bht #(.XLEN(32), .BHT_DEPTH(DEPTH), .CTR_BITS(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_pc      (fetch_pc),
    .pred_taken    (pred_taken),
    .resolve_valid (resolve_valid),
    .resolve_pc    (resolve_pc),
    .ru_rs1        (ru_rs1),
    .ru_rs2        (ru_rs2),
    .brOp          (brOp),
    .pred_in       (pred_in),
    .NextPCSrc     (NextPCSrc),
    .mispredict    (mispredict),
    .bht_clear     (bht_clear),
    .bht_busy      (bht_busy)
`ifdef BRU_BHT_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int   tag;
    logic nps;
    logic misp;
    logic pred;
    logic busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   step_no = 0;

  // Reference model state
  int ctr[DEPTH];
  int clr_left;
  longint m_branches;
  longint m_misp;

  task automatic check(input string name, input int tag, input logic act, input logic req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0b expected %0b", name, tag, act, req);
    end
  endtask

  function automatic logic ref_outcome(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = int'(a);
    sb = int'(b);
    case (op)
      5'd8:    return a == b;
      5'd9:    return a != b;
      5'd12:   return sa < sb;
      5'd13:   return sa >= sb;
      5'd14:   return a < b;
      5'd15:   return a >= b;
      default: return op >= 5'd16;
    endcase
  endfunction

  function automatic logic ref_cond(input logic [4:0] op);
    return (op == 5'd8) || (op == 5'd9) || (op >= 5'd12 && op <= 5'd15);
  endfunction

  function automatic int pc_idx(input logic [31:0] pc);
    return int'((pc >> 2) % DEPTH);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) ctr[i] = CTR_RST;
    clr_left   = 0;
    m_branches = 0;
    m_misp     = 0;
  endtask

  // One cycle: drive, predict, wait for the edge, then advance the model.
  task automatic step(input logic [31:0] fpc, input logic rv, input logic [31:0] rpc,
                      input logic [31:0] a, input logic [31:0] b, input logic [4:0] op,
                      input logic pin, input logic clr);
    exp_t e;
    logic t, c, mp;
    fetch_pc = fpc; resolve_valid = rv; resolve_pc = rpc;
    ru_rs1 = a; ru_rs2 = b; brOp = op; pred_in = pin; bht_clear = clr;
    t  = ref_outcome(op, a, b);
    c  = ref_cond(op);
    mp = rv && c && (t != pin);
    e.tag  = step_no;
    e.nps  = t;
    e.misp = mp;
    e.busy = (clr_left > 0);
    e.pred = (clr_left > 0) ? 1'b0 : (ctr[pc_idx(fpc)] >= 2);
    exp_q.push_back(e);
    @(posedge clk);
    if (mp) m_misp++;
    if (clr_left > 0) begin
      ctr[DEPTH - clr_left] = CTR_RST;
      clr_left--;
    end else begin
      if (rv && c) begin
        m_branches++;
        if (t) ctr[pc_idx(rpc)] = (ctr[pc_idx(rpc)] < CTR_MAX) ? ctr[pc_idx(rpc)] + 1 : CTR_MAX;
        else   ctr[pc_idx(rpc)] = (ctr[pc_idx(rpc)] > 0) ? ctr[pc_idx(rpc)] - 1 : 0;
      end
      if (clr) clr_left = DEPTH;
    end
    step_no++;
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("NextPCSrc",  e.tag, NextPCSrc,  e.nps);
      check("mispredict", e.tag, mispredict, e.misp);
      check("pred_taken", e.tag, pred_taken, e.pred);
      check("bht_busy",   e.tag, bht_busy,   e.busy);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  op;
    logic [31:0] a, b, fpc, rpc;
    rst_n = 1'b0;
    fetch_pc = 32'h40; resolve_valid = 1'b0; resolve_pc = '0;
    ru_rs1 = '0; ru_rs2 = '0; brOp = 5'd0; pred_in = 1'b0; bht_clear = 1'b0;
    model_reset();
    #12;
    check("reset_busy", -1, bht_busy, 1'b0);
    check("reset_pred", -1, pred_taken, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Compare ops with rs1 = -1, rs2 = 1
    step(32'h80, 1'b1, 32'h80, 32'hFFFF_FFFF, 32'd1, 5'b01100, 1'b0, 1'b0);
    step(32'h80, 1'b1, 32'h84, 32'hFFFF_FFFF, 32'd1, 5'b01110, 1'b0, 1'b0);
    step(32'h80, 1'b1, 32'h88, 32'hFFFF_FFFF, 32'd1, 5'b01101, 1'b0, 1'b0);
    step(32'h80, 1'b1, 32'h8C, 32'hFFFF_FFFF, 32'd1, 5'b01111, 1'b0, 1'b0);
    step(32'h90, 1'b1, 32'h90, 32'hFFFF_FFFF, 32'd1, 5'b01010, 1'b1, 1'b0);
    step(32'h90, 1'b0, 32'h90, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);

    // Training, saturation, same-cycle read of old value, aliasing via 0x140
    repeat (3) step(32'h40, 1'b1, 32'h40, 32'd7, 32'd7, 5'b01000, 1'b0, 1'b0);
    step(32'h140, 1'b1, 32'h140, 32'd7, 32'd7, 5'b01000, 1'b1, 1'b0);
    repeat (2) step(32'h40, 1'b1, 32'h140, 32'd1, 32'd2, 5'b01000, 1'b1, 1'b0);
    step(32'h40, 1'b0, 32'h40, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);

    // Mispredict and jump
    step(32'h44, 1'b1, 32'h44, 32'd3, 32'd4, 5'b01000, 1'b1, 1'b0);
    step(32'h44, 1'b1, 32'h44, 32'd3, 32'd4, 5'b10000, 1'b0, 1'b0);
    step(32'h44, 1'b1, 32'h44, 32'd3, 32'd4, 5'b10000, 1'b1, 1'b0);
    step(32'h44, 1'b0, 32'h44, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);

    // Flush after training entry 5 to 3; resolves during flush must not train
    repeat (3) step(32'h14, 1'b1, 32'h14, 32'd1, 32'd1, 5'b01000, 1'b0, 1'b0);
    step(32'h14, 1'b0, 32'h14, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++)
      step(32'h14, 1'b1, 32'h14, 32'd1, 32'd1, 5'b01000, 1'b0, (i == 3));
    step(32'h14, 1'b0, 32'h14, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    step(32'h14, 1'b1, 32'h14, 32'd1, 32'd1, 5'b01000, 1'b0, 1'b0);
    step(32'h14, 1'b0, 32'h14, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);

    // Randomised traffic over a small PC set to exercise collisions
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0: op = 5'b01000; 1: op = 5'b01001; 2: op = 5'b01100; 3: op = 5'b01101;
        4: op = 5'b01110; 5: op = 5'b01111; 6: op = 5'b10000 | 5'($urandom_range(0, 15));
        7: op = 5'($urandom_range(0, 7));
        8: op = 5'b01010 | 5'($urandom_range(0, 1));
        default: op = 5'($urandom);
      endcase
      a   = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 3));
      b   = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 3));
      fpc = 32'($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3)) | (32'($urandom_range(0, 1)) << 8);
      rpc = 32'($urandom_range(0, 15) << 2) | (32'($urandom_range(0, 1)) << 8);
      step(fpc, 1'($urandom_range(0, 3) != 0), rpc, a, b, op, 1'($urandom),
           ($urandom_range(0, 199) == 0));
    end
    while (clr_left > 0) step(32'h0, 1'b0, 32'h0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);

`ifdef BRU_BHT_STATS_EN
    check("stat_branches_lo",    -2, stat_branches    == 32'(m_branches), 1'b1);
    check("stat_mispredicts_lo", -2, stat_mispredicts == 32'(m_misp),     1'b1);
`endif

    // Reset in the middle of a flush: busy drops at once, table back to reset value
    repeat (3) step(32'h14, 1'b1, 32'h14, 32'd1, 32'd1, 5'b01000, 1'b0, 1'b0);
    step(32'h14, 1'b0, 32'h14, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
    repeat (10) step(32'h14, 1'b0, 32'h14, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("midflush_reset_busy", -3, bht_busy, 1'b0);
    for (int i = 0; i < 8; i++) begin
      fetch_pc = 32'(i * 4 + 8);
      #1;
      check("midflush_reset_pred", -3, pred_taken, 1'b0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(32'h14, 1'b1, 32'h14, 32'd1, 32'd1, 5'b01000, 1'b0, 1'b0);
    step(32'h14, 1'b0, 32'h14, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);

`ifdef BRU_BHT_STATS_EN
    // Four resolves with exactly one mispredict after a fresh reset
    rst_n = 1'b0; #1; model_reset(); @(posedge clk); #1; rst_n = 1'b1;
    step(32'h0, 1'b1, 32'h20, 32'd5, 32'd5, 5'b01000, 1'b1, 1'b0);
    step(32'h0, 1'b1, 32'h24, 32'd5, 32'd6, 5'b01001, 1'b1, 1'b0);
    step(32'h0, 1'b1, 32'h28, 32'd5, 32'd6, 5'b01110, 1'b0, 1'b0);
    step(32'h0, 1'b1, 32'h2C, 32'd5, 32'd6, 5'b01111, 1'b0, 1'b0);
    check("stat_branches",    -4, stat_branches    == 32'd4, 1'b1);
    check("stat_mispredicts", -4, stat_mispredicts == 32'd1, 1'b1);
    check("stat_model",       -4, (m_branches == 4) && (m_misp == 1), 1'b1);
`endif

    @(negedge clk); #1;
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bru_bht.md
# bru_bht

Parametrised branch unit for the rv32i core: resolves the condition for all BrOp encodings, as the single-cycle BRU does, and adds a direct-mapped branch history table (BHT) of saturating counters. The table supplies a taken/not-taken prediction at fetch and trains on every resolved conditional branch. The block sits between the register unit/control unit (resolve side) and the PC mux/fetch stage (predict side). A sequenced clear engine flushes the table without resetting the core.

## Interface
Parameters:
- XLEN, 32: operand and PC width.
- BHT_DEPTH, 64: number of table entries; power of two, minimum 4.
- CTR_BITS, 2: counter width; minimum 1.

Ports:
- clk  in  1  core clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- fetch_pc  in  XLEN  PC being fetched.
- pred_taken  out  1  prediction for fetch_pc; combinational from table state.
- resolve_valid  in  1  a branch/jump is being resolved this cycle.
- resolve_pc  in  XLEN  PC of the resolving instruction.
- ru_rs1  in  XLEN  rs1 operand from the register unit.
- ru_rs2  in  XLEN  rs2 operand from the register unit.
- brOp  in  5  branch operation from the control unit; same encoding as the single-cycle BRU.
- pred_in  in  1  prediction originally issued for resolve_pc.
- NextPCSrc  out  1  actual outcome, combinational.
- mispredict  out  1  combinational; equals resolve_valid & conditional & (NextPCSrc != pred_in).
- bht_clear  in  1  single-cycle pulse; starts a table flush.
- bht_busy  out  1  high while a flush is in progress.

## Operation
- **Outcome.** NextPCSrc is decoded from brOp exactly as in the single-cycle BRU:
  - 01000 =, 01001 !=, 01100 < signed, 01101 >= signed, 01110 < unsigned, 01111 >= unsigned.
  - 1XXXX gives 1.
  - 00XXX and all other codes give 0.
  - The outcome is independent of resolve_valid.
- **Conditional branch.** "Conditional" means brOp is one of the six codes above.
- **Indexing.** idx = pc[$clog2(BHT_DEPTH)+1:2]. Bits [1:0] are ignored.
- **Prediction.** pred_taken = MSB of counter[idx(fetch_pc)]. While bht_busy is high, pred_taken = 0.
- **Training.** On a clock edge where resolve_valid is high, the op is conditional and bht_busy is low:
  - counter[idx(resolve_pc)] increments if taken, decrements if not.
  - The counter saturates at 2^CTR_BITS−1 and at 0.
- **No training for other ops.** Jumps (1XXXX), no-branch ops and illegal codes never train. mispredict = 0 for these.
- **FSM states:**
  - IDLE: the default state. bht_clear moves to CLEAR with the pointer at 0.
  - CLEAR: each cycle writes the reset value to entry[ptr] and increments ptr. After writing entry BHT_DEPTH−1, returns to IDLE.
  - bht_busy = (state == CLEAR).
  - bht_clear while in CLEAR is ignored.
  - resolve_valid during CLEAR still drives NextPCSrc and mispredict, but training is dropped.
- **Counter reset value.** 2^(CTR_BITS−1)−1, i.e. weakly not-taken; for CTR_BITS=1 this is 0.

## Timing
- NextPCSrc, mispredict and pred_taken have zero latency and are combinational.
- A counter update is visible on pred_taken the cycle after the training edge.
- **Same-index read and write in one cycle.** pred_taken returns the pre-update value; there is no bypass.
- **Flush length.** Exactly BHT_DEPTH cycles. bht_busy rises the cycle after the bht_clear edge and falls after BHT_DEPTH cycles high.
- **Reset values.** Asserting rst_n low at any time, including mid-flush, forces:
  - state IDLE, ptr 0, every counter to the reset value, bht_busy 0;
  - pred_taken 0 for CTR_BITS ≥ 2 (it reads a reset-value counter).
- **Reset release.** Deassertion is synchronised externally; the first functional edge is the first clk rise with rst_n high.

## Configuration
- Macro: BRU_BHT_STATS_EN.
- **Defined:** adds output ports stat_branches [31:0] and stat_mispredicts [31:0].
  - stat_branches counts training-eligible resolves.
  - stat_mispredicts counts edges where mispredict is high.
  - Both saturate at 32'hFFFF_FFFF and are cleared only by rst_n.
- **Undefined:** the ports and counters are absent; all other behaviour is identical.

## Structure
- **Package bru_pkg** holds:
  - brOp code localparams: BR_NONE, BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU, and a BR_JUMP mask;
  - the FSM state typedef bht_state_t {IDLE, CLEAR};
  - a function returning the counter reset value for a given CTR_BITS.
- **Sub-module sat_counter** (parameter CTR_BITS): given cur, inc, dec, returns the saturated next value. It is instantiated once, on the write path.
- **Table:** a flop array with an asynchronous reset (not inferred RAM), so that reset clears every entry in one step.

## Test plan
- **Compare ops.** rs1=0xFFFF_FFFF, rs2=1:
  - 01100 gives 1, 01110 gives 0, 01101 gives 0, 01111 gives 1;
  - brOp 01010 gives 0 with no training.
- **Training and saturation.** Three taken resolves at PC 0x40 (CTR_BITS=2):
  - pred_taken for fetch_pc 0x40 goes 0, then 1 after the first edge, stays 1;
  - the counter saturates at 3;
  - two not-taken resolves then give pred_taken 0.
- **Aliasing and bypass.** With BHT_DEPTH=64, PC 0x40 and 0x140 share an entry. Same-cycle resolve and fetch at 0x40 returns the old prediction.
- **Mispredict and jumps.**
  - pred_in=1, BEQ with rs1≠rs2 gives mispredict=1.
  - brOp 10000 gives NextPCSrc=1, mispredict=0, and the table is unchanged.
- **Flush.** Pulse bht_clear after training entry 5 to 3:
  - bht_busy is high for exactly 64 cycles and pred_taken is 0 throughout;
  - resolves during the flush do not train;
  - entry 5 reads the reset value afterwards.
- **Reset and stats.**
  - rst_n low at flush cycle 10 gives bht_busy 0 immediately and all entries at the reset value.
  - With BRU_BHT_STATS_EN: 4 resolves with 1 mispredict give stat_branches=4, stat_mispredicts=1.
